// File: rtl/modaddsub_seq.sv
// Sequential modular add/subtract over a 381-bit field, built from CHUNK-wide slices.
// A raw pass forms a+b or a-b, then a correction pass subtracts or adds the modulus.
module modaddsub_seq #(
  parameter int CHUNK = 127
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         subtract,
  input  logic [380:0] in_a,
  input  logic [380:0] in_b,
  input  logic [380:0] in_m,
  output logic [380:0] result,
  output logic         done
);

  localparam int W   = 381;
  localparam int NCH = W / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RAW, COR} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic           carry_q, c_q, bo_q, sub_q, done_q;
  logic [W-1:0]   a_q, b_q, m_q, raw_q, cor_q, result_q;
  logic [W-1:0]   raw_d, cor_d;

  logic [CHUNK-1:0] aSlice, bSlice, mSlice, rawSlice;
  logic [CHUNK-1:0] opA, opB;
  logic [CHUNK:0]   sumS;
  logic             doSub;
  logic             boNow;
  logic [W-1:0]     finalRes;

  // Slice selection and the single CHUNK+1 bit add/subtract shared by both passes.
  always_comb begin
    aSlice   = '0;
    bSlice   = '0;
    mSlice   = '0;
    rawSlice = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_q == CW'(i)) begin
        aSlice   = a_q[i*CHUNK +: CHUNK];
        bSlice   = b_q[i*CHUNK +: CHUNK];
        mSlice   = m_q[i*CHUNK +: CHUNK];
        rawSlice = raw_q[i*CHUNK +: CHUNK];
      end
    end
    opA   = (state_q == COR) ? rawSlice : aSlice;
    opB   = (state_q == COR) ? mSlice : bSlice;
    doSub = (state_q == COR) ? ~sub_q : sub_q;
    if (doSub)
      sumS = {1'b0, opA} - {1'b0, opB} - {{CHUNK{1'b0}}, carry_q};
    else
      sumS = {1'b0, opA} + {1'b0, opB} + {{CHUNK{1'b0}}, carry_q};

    raw_d = raw_q;
    cor_d = cor_q;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_q == CW'(i)) begin
        raw_d[i*CHUNK +: CHUNK] = sumS[CHUNK-1:0];
        cor_d[i*CHUNK +: CHUNK] = sumS[CHUNK-1:0];
      end
    end

    // {c,raw} - m goes negative only when no carry bit is available to absorb the final borrow.
    boNow = ~c_q & sumS[CHUNK];
    if (sub_q)
      finalRes = c_q ? cor_d : raw_q;
    else
      finalRes = boNow ? raw_q : cor_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      c_q      <= 1'b0;
      bo_q     <= 1'b0;
      sub_q    <= 1'b0;
      done_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      raw_q    <= '0;
      cor_q    <= '0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= in_a;
            b_q     <= in_b;
            m_q     <= in_m;
            sub_q   <= subtract;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= RAW;
          end
        end
        RAW: begin
          raw_q <= raw_d;
          if (cnt_q == LAST) begin
            c_q     <= sumS[CHUNK];
            carry_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= COR;
          end else begin
            carry_q <= sumS[CHUNK];
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        COR: begin
          cor_q <= cor_d;
          if (cnt_q == LAST) begin
            bo_q     <= boNow;
            result_q <= finalRes;
            done_q   <= 1'b1;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            state_q  <= IDLE;
          end else begin
            carry_q <= sumS[CHUNK];
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_modaddsub_seq.sv
// Directed and random checks of modaddsub_seq against a full-width reference model.
module tb_modaddsub_seq;

  localparam logic [383:0] P384 = 384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
  localparam logic [380:0] P    = P384[380:0];

  logic         clk = 1'b0;
  logic         resetn, start, subtract;
  logic [380:0] in_a, in_b, in_m;
  logic [380:0] result;
  logic         done;

  int passCount = 0;
  int totalCount = 0;
  int doneSeen = 0;
  int expDone = 0;

  modaddsub_seq #(.CHUNK(127)) dut (
    .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .in_m(in_m), .result(result), .done(done)
  );

  always #5 clk = ~clk;

  // Counts completion pulses independently of the stimulus tasks.
  always @(negedge clk) if (done === 1'b1) doneSeen++;

  typedef struct {
    string        name;
    logic         sub;
    logic [380:0] a;
    logic [380:0] b;
    logic [380:0] exp;
  } vec_t;

  function automatic logic [380:0] refOp(input logic s, input logic [380:0] a, input logic [380:0] b);
    logic [381:0] r;
    if (!s) begin
      r = {1'b0, a} + {1'b0, b};
      if (r >= {1'b0, P}) r = r - {1'b0, P};
    end else if (a >= b) begin
      r = {1'b0, a} - {1'b0, b};
    end else begin
      r = {1'b0, a} + {1'b0, P} - {1'b0, b};
    end
    return r[380:0];
  endfunction

  function automatic logic [380:0] randBelowP();
    logic [383:0] r;
    logic [380:0] t;
    for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
    t = r[380:0];
    return t % P;
  endfunction

  task automatic checkOutput(input string name, input logic [380:0] got, input logic [380:0] exp);
    totalCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Launches one operation from IDLE and waits (bounded) for its done pulse.
  task automatic applyStimulus(input logic s, input logic [380:0] a, input logic [380:0] b,
                               input bit noise, output logic [380:0] res, output int lat,
                               output logic pulseLow);
    start = 1'b1; subtract = s; in_a = a; in_b = b; in_m = P;
    @(posedge clk); #1;
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      if (noise && k <= 5) begin
        start = 1'b1; subtract = ~s;
        in_a = randBelowP(); in_b = randBelowP(); in_m = randBelowP();
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done === 1'b1) lat = k + 1;
    end
    res = result;
    start = 1'b0;
    @(posedge clk); #1;
    pulseLow = (done === 1'b0);
  endtask

  task automatic runAndCheck(input string name, input logic s, input logic [380:0] a,
                             input logic [380:0] b, input logic [380:0] exp, input bit noise);
    logic [380:0] res;
    int lat;
    logic pulseLow;
    applyStimulus(s, a, b, noise, res, lat, pulseLow);
    expDone++;
    checkOutput({name, "_latency"}, 381'(lat), 381'(7));
    checkOutput({name, "_result"}, res, exp);
    checkOutput({name, "_pulse"}, 381'(pulseLow), 381'(1));
  endtask

  vec_t vecs[8];
  logic [380:0] ha[28];
  logic [380:0] hb[28];
  logic         hs[28];
  bit           spurious;
  bit           sawDone;
  logic [380:0] ra, rb;
  logic         rs;

  initial begin
    vecs[0] = '{"add_1_1",        1'b0, 381'(1),   381'(1),   381'(2)};
    vecs[1] = '{"add_pm1_1",      1'b0, P - 1,     381'(1),   381'(0)};
    vecs[2] = '{"add_pm1_pm1",    1'b0, P - 1,     P - 1,     P - 2};
    vecs[3] = '{"sub_0_1",        1'b1, 381'(0),   381'(1),   P - 1};
    vecs[4] = '{"sub_5_3",        1'b1, 381'(5),   381'(3),   381'(2)};
    vecs[5] = '{"sub_3_5",        1'b1, 381'(3),   381'(5),   P - 2};
    vecs[6] = '{"sub_pm1_pm1",    1'b1, P - 1,     P - 1,     381'(0)};
    vecs[7] = '{"add_0_0",        1'b0, 381'(0),   381'(0),   381'(0)};

    resetn = 1'b0; start = 1'b0; subtract = 1'b0;
    in_a = '0; in_b = '0; in_m = P;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    checkOutput("reset_done", 381'(done), 381'(0));
    checkOutput("reset_result", result, 381'(0));

    for (int i = 0; i < 8; i++)
      runAndCheck(vecs[i].name, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);

    // Start and operands toggling while busy must not disturb the operation in flight.
    runAndCheck("noisy_add", 1'b0, P - 1, 381'(2), 381'(1), 1'b1);
    runAndCheck("noisy_sub", 1'b1, 381'(4), 381'(9), P - 5, 1'b1);

    // Start held high: accepts every 7 cycles using operands at each accepting edge.
    spurious = 1'b0;
    for (int j = 0; j < 28; j++) begin
      ha[j] = 381'(100 + j); hb[j] = 381'(3 * j); hs[j] = (j % 2) == 1;
      start = 1'b1; in_a = ha[j]; in_b = hb[j]; subtract = hs[j]; in_m = P;
      @(posedge clk); #1;
      if ((j + 1) % 7 == 0) begin
        checkOutput("b2b_done", 381'(done), 381'(1));
        checkOutput("b2b_result", result, refOp(hs[j-6], ha[j-6], hb[j-6]));
      end else if (done !== 1'b0) begin
        spurious = 1'b1;
      end
    end
    start = 1'b0;
    expDone += 4;
    checkOutput("b2b_no_spurious", 381'(spurious), 381'(0));
    @(posedge clk); #1;

    // Reset during the second RAW cycle aborts the operation silently.
    start = 1'b1; subtract = 1'b0; in_a = 381'(7); in_b = 381'(8);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    checkOutput("abort_result", result, 381'(0));
    checkOutput("abort_done", 381'(done), 381'(0));
    runAndCheck("after_reset_add_2_3", 1'b0, 381'(2), 381'(3), 381'(5), 1'b0);
    sawDone = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done !== 1'b0) sawDone = 1'b1;
    end
    checkOutput("idle_no_done", 381'(sawDone), 381'(0));

    for (int n = 0; n < 1000; n++) begin
      ra = randBelowP(); rb = randBelowP(); rs = 1'($urandom_range(0, 1));
      runAndCheck("random", rs, ra, rb, refOp(rs, ra, rb), 1'b0);
    end

    @(posedge clk); #1;
    checkOutput("done_count", 381'(doneSeen), 381'(expDone));

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
